// File: rtl/key_comp_pkg.sv
// key_comp_pkg -- shared definitions for the sequential key comparator.
//   MODE_*   : request mode encodings carried on in_mode (2'b11 is reserved
//              and treated like MODE_EQ).
//   state_t  : FSM state encoding (IDLE / SCAN / DONE).
//   mode_uses_mask() : 1 when the care mask participates in the compare.
package key_comp_pkg;

  localparam logic [1:0] MODE_EQ     = 2'b00;
  localparam logic [1:0] MODE_MASKED = 2'b01;
  localparam logic [1:0] MODE_MAG    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic mode_uses_mask(input logic [1:0] mode);
    return (mode == MODE_MASKED);
  endfunction

endpackage

// File: rtl/chunk_comp.sv
// chunk_comp -- combinational compare of one CHUNK-bit slice.
//   a, b  : operand slices
//   mask  : care bits (1 = compare)
//   diff  : 1 when any cared-for bit differs
//   lt    : unsigned a < b over the full slice (mask ignored; the caller
//           only uses it for unmasked magnitude compares)
module chunk_comp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [CHUNK-1:0] mask,
  output logic             diff,
  output logic             lt
);

  assign diff = |((a ^ b) & mask);
  assign lt   = (a < b);

endmodule

// File: rtl/seq_key_comp.sv
// seq_key_comp -- multi-cycle key comparator, one CHUNK slice per cycle,
// scanning MSB-first with early termination on the first differing slice.
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : request handshake (one request in flight)
//   in_a, in_b, in_mask    : operands and care mask (mask used in MASKED only)
//   in_mode                : 00 EQ, 01 MASKED, 10 MAG, 11 behaves as EQ
//   out_valid/out_ready    : result handshake
//   out_match, out_lt      : result; held until the result handshake and
//                            retained afterwards
module seq_key_comp
  import key_comp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_mask,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_match,
  output logic             out_lt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [1:0]        mode_q, mode_d;
  logic              match_q, match_d;
  logic              lt_q, lt_d;

  // Captured operands split into per-chunk slices so the scan is a plain mux.
  logic [CHUNK-1:0]  a_sl    [NCHUNK];
  logic [CHUNK-1:0]  b_sl    [NCHUNK];
  logic [CHUNK-1:0]  mask_sl [NCHUNK];

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
    assign a_sl[gi]    = a_q[gi*CHUNK +: CHUNK];
    assign b_sl[gi]    = b_q[gi*CHUNK +: CHUNK];
    assign mask_sl[gi] = mask_q[gi*CHUNK +: CHUNK];
  end

  logic [CHUNK-1:0]  cur_a, cur_b, cur_mask;
  logic              slice_diff, slice_lt;

  assign cur_a    = a_sl[idx_q];
  assign cur_b    = b_sl[idx_q];
  // Outside MASKED mode every bit is cared for.
  assign cur_mask = mode_uses_mask(mode_q) ? mask_sl[idx_q] : {CHUNK{1'b1}};

  chunk_comp #(
    .CHUNK (CHUNK)
  ) u_chunk_comp (
    .a    (cur_a),
    .b    (cur_b),
    .mask (cur_mask),
    .diff (slice_diff),
    .lt   (slice_lt)
  );

  // State register plus the request/result datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mask_q  <= '0;
      mode_q  <= MODE_EQ;
      match_q <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      match_q <= match_d;
      lt_q    <= lt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)                      state_d = ST_SCAN;
      ST_SCAN: if (slice_diff || (idx_q == '0))   state_d = ST_DONE;
      ST_DONE: if (out_ready)                     state_d = ST_IDLE;
      default:                                    state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: capture on accept, walk idx down while scanning.
  always_comb begin
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    match_d = match_q;
    lt_d    = lt_q;
    if (state_q == ST_IDLE) begin
      if (in_valid) begin
        a_d    = in_a;
        b_d    = in_b;
        mask_d = in_mask;
        mode_d = in_mode;
        idx_d  = IDX_LAST;
      end
    end else if (state_q == ST_SCAN) begin
      if (slice_diff) begin
        // First differing slice from the MSB decides the magnitude order.
        match_d = 1'b0;
        lt_d    = (mode_q == MODE_MAG) && slice_lt;
      end else if (idx_q == '0) begin
        match_d = 1'b1;
        lt_d    = 1'b0;
      end else begin
        idx_d = idx_q - 1'b1;
      end
    end
  end

  // Outputs: handshake flags decode the state; results come from registers.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    out_match = match_q;
    out_lt    = lt_q;
  end

endmodule

// File: tb/tb_seq_key_comp.sv
module tb_seq_key_comp;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b, in_mask;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic        out_match;
  logic        out_lt;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic match;
    logic lt;
    int   lat;
  } exp_t;

  exp_t sb[$];

  seq_key_comp #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mask   (in_mask),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_match (out_match),
    .out_lt    (out_lt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s miscompare", tag);
    end
  endtask

  // Reference: scan bytes MSB-first, first differing cared-for byte decides.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] m, input logic [1:0] mode);
    exp_t e;
    logic [7:0] sa, sb_, sm;
    e.match = 1'b1; e.lt = 1'b0; e.lat = 4;
    for (int j = 1; j <= 4; j++) begin
      sa  = a[(4-j)*8 +: 8];
      sb_ = b[(4-j)*8 +: 8];
      sm  = (mode == 2'b01) ? m[(4-j)*8 +: 8] : 8'hFF;
      if (((sa ^ sb_) & sm) != 8'h00) begin
        e.match = 1'b0;
        e.lt    = (mode == 2'b10) && (sa < sb_);
        e.lat   = j;
        return e;
      end
    end
    return e;
  endfunction

  // Expects to be called at posedge+1 with the DUT idle. If try_next is set,
  // in_valid is held high through the result handshake to probe for a bypass.
  task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] m, input logic [1:0] mode,
                         input logic e_match, input logic e_lt, input int e_lat,
                         input int hold, input bit try_next);
    exp_t e;
    int   lat;
    chk({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_mask = m; in_mode = mode; in_valid = 1'b1;
    sb.push_back('{e_match, e_lt, e_lat});
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_mask = $urandom; in_mode = 2'($urandom);
    chk({tag, "/in_ready_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/out_valid"}, 32'(out_valid), 32'd1);
    if (out_valid) begin
      e = sb.pop_front();
      $display("%s: a=%h b=%h m=%h mode=%0d lat=%0d match=%0b lt=%0b",
               tag, a, b, m, mode, lat, out_match, out_lt);
      chk({tag, "/latency"}, 32'(lat), 32'(e.lat));
      chk({tag, "/match"}, 32'(out_match), 32'(e.match));
      chk({tag, "/lt"}, 32'(out_lt), 32'(e.lt));
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "/hold_match"}, 32'(out_match), 32'(e.match));
        chk({tag, "/hold_lt"}, 32'(out_lt), 32'(e.lt));
        chk({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      if (try_next) in_valid = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "/post_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "/post_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "/retain_match"}, 32'(out_match), 32'(e.match));
    end else begin
      sb.delete();
    end
  endtask

  initial begin
    exp_t        e;
    logic [31:0] ra, rb, rm;
    logic [1:0]  rmode;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_mask = '0; in_mode = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/out_valid", 32'(out_valid), 32'd0);
    chk("reset/in_ready", 32'(in_ready), 32'd1);
    chk("reset/out_match", 32'(out_match), 32'd0);
    chk("reset/out_lt", 32'(out_lt), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed scenarios
    run_req("eq_match",   32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 2'b00, 1'b1, 1'b0, 4, 0, 1'b0);
    run_req("eq_diff",    32'h12345678, 32'h13345678, 32'h0, 2'b00, 1'b0, 1'b0, 1, 0, 1'b0);
    run_req("mag_lt",     32'hAABB0010, 32'hAABB0020, 32'h0, 2'b10, 1'b0, 1'b1, 4, 0, 1'b0);
    run_req("mag_gt",     32'hAABB0020, 32'hAABB0010, 32'h0, 2'b10, 1'b0, 1'b0, 4, 0, 1'b0);
    run_req("msk_part",   32'hFF00FF00, 32'h0000FF00, 32'h00FFFFFF, 2'b01, 1'b1, 1'b0, 4, 0, 1'b0);
    run_req("msk_full",   32'hFF00FF00, 32'h0000FF00, 32'hFFFFFFFF, 2'b01, 1'b0, 1'b0, 1, 0, 1'b0);
    run_req("msk_zero",   32'h12345678, 32'h87654321, 32'h00000000, 2'b01, 1'b1, 1'b0, 4, 0, 1'b0);
    run_req("mag_top",    32'h01000000, 32'h02000000, 32'h0, 2'b10, 1'b0, 1'b1, 1, 0, 1'b0);
    run_req("rsv_as_eq",  32'h00000001, 32'h00000000, 32'hFFFFFFFF, 2'b11, 1'b0, 1'b0, 4, 0, 1'b0);
    run_req("eq_mask_ign",32'h000000FF, 32'h00000000, 32'h00000000, 2'b00, 1'b0, 1'b0, 4, 0, 1'b0);

    // Backpressure in DONE, with in_valid raised during the result handshake
    run_req("hold5",      32'h00110000, 32'h00220000, 32'h0, 2'b10, 1'b0, 1'b1, 2, 5, 1'b1);
    run_req("after_hold", 32'h55555555, 32'h55555555, 32'h0, 2'b00, 1'b1, 1'b0, 4, 0, 1'b0);

    // Reset in the second SCAN cycle aborts; prior match=1 must be cleared
    chk("abort/in_ready_idle", 32'(in_ready), 32'd1);
    in_a = 32'hCAFEF00D; in_b = 32'hCAFEF00D; in_mode = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("abort: out_valid=%0b in_ready=%0b match=%0b", out_valid, in_ready, out_match);
    chk("abort/out_valid", 32'(out_valid), 32'd0);
    chk("abort/in_ready", 32'(in_ready), 32'd1);
    chk("abort/out_match", 32'(out_match), 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort/no_result", 32'(out_valid), 32'd0);
    end
    run_req("post_abort", 32'hA5A5A5A5, 32'hA5A5A5A4, 32'h0, 2'b10, 1'b0, 1'b0, 4, 0, 1'b0);

    // Randomised requests checked against the reference model
    for (int i = 0; i < 8; i++) begin
      ra    = $urandom;
      rb    = ra ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
      rm    = $urandom;
      rmode = 2'($urandom_range(0, 3));
      if (i == 0) rb = ra;
      e = model(ra, rb, rm, rmode);
      run_req("rand", ra, rb, rm, rmode, e.match, e.lt, e.lat, i % 3, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_key_comp.md
SEQ_KEY_COMP -- requirements
Module: seq_key_comp

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the key width in bits.
REQ-002 The module SHALL have parameter CHUNK, default 8, giving the bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: request valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-007 The module SHALL have ports in_a and in_b, input, WIDTH bits each: operands.
REQ-008 The module SHALL have port in_mask, input, WIDTH bits: care mask, where 1 = compare; used in MASKED mode only.
REQ-009 The module SHALL have port in_mode, input, 2 bits: 00 EQ, 01 MASKED, 10 MAG, 11 reserved (behaves as EQ).
REQ-010 The module SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 The module SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 The module SHALL have port out_match, output, 1 bit: the operands are equal under the active mode.
REQ-013 The module SHALL have port out_lt, output, 1 bit: in_a < in_b, unsigned; meaningful in MAG mode only and 0 in all other modes.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; it SHALL be 0 in SCAN and DONE, so only one request is in flight.
REQ-016 A request SHALL be accepted on a clock edge where in_valid and in_ready are both 1. On acceptance the block SHALL register a, b, mask and mode, set chunk index idx to NCHUNK-1, and move to SCAN.
REQ-017 In SCAN, each cycle SHALL compare one CHUNK slice, idx*CHUNK+CHUNK-1 down to idx*CHUNK, MSB-first.
REQ-018 A slice SHALL differ when (a_slice ^ b_slice) & eff_mask is nonzero, where eff_mask = mask slice in MASKED mode and all-ones otherwise.
REQ-019 If the slice differs, the block SHALL register out_match=0 and out_lt=(mode==MAG)&(a_slice<b_slice), then go to DONE (early termination).
REQ-020 If the slice matches and idx==0, the block SHALL register out_match=1 and out_lt=0, then go to DONE.
REQ-021 If the slice matches and idx>0, idx SHALL decrement and the block SHALL stay in SCAN.
REQ-022 Latency: with the first differing slice at position j counted from the MSB (1..NCHUNK), out_valid SHALL be 1 in the cycle after j edges following the accept edge; a full match SHALL take NCHUNK edges.
REQ-023 In DONE, out_valid SHALL be 1, and out_match and out_lt SHALL be held stable until the edge where out_ready=1; that edge SHALL move the block to IDLE.
REQ-024 There SHALL be no same-cycle bypass from DONE to accept: in_ready rises only in the cycle after the result handshake.
REQ-025 out_valid SHALL be 0 in IDLE and SCAN; out_match and out_lt SHALL retain their last values outside DONE.
REQ-026 MASKED mode with in_mask all zeros SHALL give out_match=1 after NCHUNK edges.
REQ-027 With NCHUNK=1, SCAN SHALL last exactly one cycle.
REQ-028 Changes on in_a, in_b, in_mask or in_mode after acceptance SHALL have no effect on the request in flight.

Reset
REQ-029 When rst=1 at a clock edge, the block SHALL go to IDLE, set idx=0, out_valid=0, out_match=0 and out_lt=0; in_ready SHALL be 1 after reset deasserts.
REQ-030 rst asserted in SCAN or DONE SHALL abort the operation with no result delivered; rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-031 Package key_comp_pkg SHALL hold the mode encodings (MODE_EQ, MODE_MASKED, MODE_MAG) and the FSM state typedef.
REQ-032 One combinational sub-module, chunk_comp, SHALL be parametrised by CHUNK, with inputs a, b and mask and outputs diff and lt; seq_key_comp SHALL instantiate it once.

Verification (WIDTH=32, CHUNK=8)
REQ-033 Scenario 1: EQ, a=b=0xDEADBEEF -> out_valid 4 edges after accept; match=1, lt=0.
REQ-034 Scenario 2: EQ, a=0x12345678, b=0x13345678 -> out_valid 1 edge after accept; match=0.
REQ-035 Scenario 3: MAG, a=0xAABB0010, b=0xAABB0020 -> 4 edges; match=0, lt=1; swapping a and b -> lt=0.
REQ-036 Scenario 4: MASKED, a=0xFF00FF00, b=0x0000FF00, mask=0x00FFFFFF -> match=1 after 4 edges; with mask=0xFFFFFFFF -> match=0 after 1 edge.
REQ-037 Scenario 5: hold out_ready=0 for 5 cycles in DONE -> out_valid and the result stay stable, in_ready=0 throughout; the next request is accepted only the cycle after the handshake.
REQ-038 Scenario 6: assert rst during the second SCAN cycle -> next cycle IDLE with out_valid=0 and in_ready=1; a new request then completes normally.
